// File: rtl/pipe_stall_if.sv
// Handshake bundle between the pipeline datapath and the stall/flush controller.
// master: pipeline side (drives hazard/memory status, consumes keep/flush controls).
// slave:  pipe_stall_ctrl.
interface pipe_stall_if #(
  parameter int unsigned R_WIDTH = 5,
  parameter int unsigned PERF_W  = 16
);
  logic [R_WIDTH-1:0] id_rs_i;
  logic [R_WIDTH-1:0] id_rt_i;
  logic               id_uses_rt_i;
  logic               ex_mem_read_i;
  logic [R_WIDTH-1:0] ex_rd_i;
  logic               branch_taken_i;
  logic               mem_req_i;
  logic               mem_ack_i;

  logic               keep_pc_o;
  logic               keep_ifid_o;
  logic               keep_idex_o;
  logic               keep_exmem_o;
  logic               keep_memwb_o;
  logic               flush_ifid_o;
  logic               flush_idex_o;
  logic               mem_busy_o;
  logic               mem_timeout_o;
  logic [PERF_W-1:0]  stall_cnt_o;

  modport master (
    output id_rs_i, id_rt_i, id_uses_rt_i, ex_mem_read_i, ex_rd_i,
           branch_taken_i, mem_req_i, mem_ack_i,
    input  keep_pc_o, keep_ifid_o, keep_idex_o, keep_exmem_o, keep_memwb_o,
           flush_ifid_o, flush_idex_o, mem_busy_o, mem_timeout_o, stall_cnt_o
  );

  modport slave (
    input  id_rs_i, id_rt_i, id_uses_rt_i, ex_mem_read_i, ex_rd_i,
           branch_taken_i, mem_req_i, mem_ack_i,
    output keep_pc_o, keep_ifid_o, keep_idex_o, keep_exmem_o, keep_memwb_o,
           flush_ifid_o, flush_idex_o, mem_busy_o, mem_timeout_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits
// (with timeout into a sticky error state). keep/flush outputs are Mealy.
// Optional stall-cycle performance counter: define PIPE_STALL_PERF_CNT_EN to build it;
// otherwise stall_cnt_o is tied to zero.
module pipe_stall_ctrl #(
  parameter int unsigned R_WIDTH = 5,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned PERF_W  = 16
) (
  input logic       clk_i,
  input logic       rst_n_i,
  pipe_stall_if.slave bus
);

  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StMemWait = 2'd1;
  localparam logic [1:0] StErr     = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [R_WIDTH-1:0] ex_rd;
  logic               load_use;
  logic               keep_all;
  logic               keep_front;
  logic               flush_ifid;
  logic               flush_idex;

  assign ex_rd    = bus.ex_rd_i;
  assign load_use = bus.ex_mem_read_i && (ex_rd != '0) &&
                    ((ex_rd == bus.id_rs_i) || (bus.id_uses_rt_i && (ex_rd == bus.id_rt_i)));

  // Next-state and control decode; memory wait outranks branch, branch outranks load-use.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    keep_all   = 1'b0;
    keep_front = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    case (state_q)
      StRun: begin
        if (bus.mem_req_i && !bus.mem_ack_i) begin
          keep_all   = 1'b1;
          state_d    = StMemWait;
          wait_cnt_d = CNT_W'(1);
        end else if (bus.branch_taken_i) begin
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
        end else if (load_use) begin
          keep_front = 1'b1;
          flush_idex = 1'b1;
        end
      end
      StMemWait: begin
        if (bus.mem_ack_i) begin
          // Release in the ack cycle so the pipeline advances at this edge.
          state_d    = StRun;
          wait_cnt_d = '0;
        end else begin
          keep_all = 1'b1;
          if (wait_cnt_q == CNT_W'(TIMEOUT)) begin
            state_d = StErr;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end
      end
      StErr: begin
        keep_all = 1'b1;
      end
      default: begin
        state_d    = StRun;
        wait_cnt_d = '0;
      end
    endcase
  end

  // FSM state and wait counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Controls are forced low during reset even though inputs may still request a stall.
  assign bus.keep_pc_o     = rst_n_i && (keep_all || keep_front);
  assign bus.keep_ifid_o   = rst_n_i && (keep_all || keep_front);
  assign bus.keep_idex_o   = rst_n_i && keep_all;
  assign bus.keep_exmem_o  = rst_n_i && keep_all;
  assign bus.keep_memwb_o  = rst_n_i && keep_all;
  assign bus.flush_ifid_o  = rst_n_i && flush_ifid;
  assign bus.flush_idex_o  = rst_n_i && flush_idex;
  assign bus.mem_busy_o    = (state_q == StMemWait);
  assign bus.mem_timeout_o = (state_q == StErr);

`ifdef PIPE_STALL_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q;

  // Saturating count of edges at which the PC was held.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
    end else if (bus.keep_pc_o && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + PERF_W'(1);
    end
  end

  assign bus.stall_cnt_o = stall_cnt_q;
`else
  assign bus.stall_cnt_o = {PERF_W{1'b0}};
`endif

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline; drives keep (hold) and flush (load-zero) controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and taken-branch flushes.
- Sequences multi-cycle data-memory accesses through a req/ack wait FSM with timeout.
- Sits beside the pipeline registers; outputs are consumed at the registers' next capture edge.

Parameters:
- R_WIDTH, 5: register-specifier width.
- TIMEOUT, 15: max MEM_WAIT cycles before error (1..2^CNT_W-1).
- CNT_W, 4: wait-counter width.
- PERF_W, 16: stall performance counter width.

Ports:
- clk_i  in  1  clock; state updates on rising edge, outputs settle before falling edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- id_rs_i  in  R_WIDTH  rs of instruction in ID.
- id_rt_i  in  R_WIDTH  rt of instruction in ID.
- id_uses_rt_i  in  1  ID instruction reads rt.
- ex_mem_read_i  in  1  EX instruction is a load.
- ex_rd_i  in  R_WIDTH  destination of EX instruction.
- branch_taken_i  in  1  branch/jump resolved taken in EX.
- mem_req_i  in  1  MEM-stage instruction accesses data memory.
- mem_ack_i  in  1  data memory completes access this cycle.
- keep_pc_o  out  1  hold PC.
- keep_ifid_o  out  1  hold IF/ID.
- keep_idex_o  out  1  hold ID/EX.
- keep_exmem_o  out  1  hold EX/MEM.
- keep_memwb_o  out  1  hold MEM/WB.
- flush_ifid_o  out  1  IF/ID loads zero (NOP).
- flush_idex_o  out  1  ID/EX loads zero (bubble).
- mem_busy_o  out  1  FSM in MEM_WAIT.
- mem_timeout_o  out  1  sticky timeout error.
- stall_cnt_o  out  PERF_W  stall-cycle count.

Behaviour:
- Reset (async, rst_n_i=0): state=RUN; wait_cnt=0; stall_cnt=0; mem_timeout_o=0; mem_busy_o=0. All keep/flush outputs are 0 while rst_n_i=0.
- FSM states: RUN, MEM_WAIT, ERR. keep/flush outputs are combinational from state and inputs (Mealy).
- RUN, priority order, highest first:
  1. mem_req_i=1 and mem_ack_i=0: all five keep=1; next state MEM_WAIT; wait_cnt<=1.
  2. branch_taken_i=1: flush_ifid=1, flush_idex=1, all keeps 0.
  3. Load-use: ex_mem_read_i=1, ex_rd_i!=0, and (ex_rd_i==id_rs_i or (id_uses_rt_i and ex_rd_i==id_rt_i)): keep_pc=1, keep_ifid=1, flush_idex=1. Single cycle; no state change.
  4. Otherwise all outputs 0.
  - mem_req_i=1 with mem_ack_i=1 in the same cycle is a zero-wait access: no stall.
- MEM_WAIT:
  - All keeps=1; flushes=0; branch and load-use inputs are ignored.
  - On mem_ack_i=1: all keeps=0 in that same cycle (release); next state RUN; wait_cnt<=0.
  - If mem_ack_i=0 and wait_cnt==TIMEOUT: next state ERR.
  - Otherwise wait_cnt<=wait_cnt+1.
  - Held pipeline inputs re-evaluate branch and load-use in RUN after release.
- ERR: all keeps=1; mem_timeout_o=1; flushes=0. Left only by reset. mem_ack_i is ignored.
- mem_busy_o = (state==MEM_WAIT).
- Keep and flush on the same register never both assert.
- stall_cnt increments by 1 on each rising edge where keep_pc_o=1. It saturates at 2^PERF_W-1 (no wrap).
- Reset asserted mid-MEM_WAIT: outputs drop immediately to 0; FSM returns to RUN.

Optional Feature:
- Macro PIPE_STALL_PERF_CNT_EN.
- Defined: stall_cnt register is implemented as above.
- Undefined: no counter register; stall_cnt_o is tied to 0. All other behaviour is identical.

Test Plan:
- Load-use: ex_mem_read_i=1, ex_rd_i=8, id_rs_i=8 -> exactly one cycle of keep_pc=keep_ifid=flush_idex=1. Repeat with ex_rd_i=0 -> no stall.
- Branch vs load-use: branch_taken_i=1 together with a load-use match -> flush_ifid=flush_idex=1, keep_pc=0.
- Memory wait: mem_req_i=1, ack after 3 cycles -> mem_busy_o=1 and all keeps=1 for 3 cycles, released in the ack cycle. stall_cnt_o advances by 4 (3 wait cycles + entry cycle).
- Timeout: mem_req_i=1, no ack, TIMEOUT=15 -> ERR after 15 MEM_WAIT cycles. mem_timeout_o=1 and keeps stay 1 while ack is later pulsed; cleared only by rst_n_i.
- Async reset mid-wait: drop rst_n_i between clock edges in MEM_WAIT -> all outputs 0 immediately; state RUN after release.
- Saturation (PERF_W=4, macro defined): 20 stalled cycles -> stall_cnt_o=15. With macro undefined -> stall_cnt_o=0.
